// File: rtl/data_dispatcher_unit.sv
// -----------------------------------------------------------------------------
// data_dispatcher_unit
//
// Scatters a serial byte stream into a destination block RAM. Each byte of a
// message is written to the address held in a dispatch table at the entry
// for that byte's position in the message. Two message types share the table:
// particle messages use entries [0, PARTICLE_LEN) and map messages use entries
// [PARTICLE_LEN, PARTICLE_LEN+MAP_LEN). A one-cycle start_particle_update
// pulse accompanies the write of the last byte of every particle message.
//
// The table is an inferred ROM. Its contents come from the dispatch_table
// parameter, which is a packed vector holding one ADDR_WIDTH-bit entry per
// slot, with entry i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]. The default value
// holds a linear layout: particle slot i maps to 0x100+i, and map slot i
// maps to 0x200+i.
//
// Pipeline (E0 = accept edge):
//   E0   : byte latched, table index registered, counter advances
//   E0+1 : table entry read (registered ROM read)
//   E0+2 : data_out / waddr / data_valid (/ start_particle_update) driven
//
// Ports
//   clk                    in   single clock, rising edge
//   rst_n                  in   asynchronous active-low reset
//   data_in                in   incoming byte
//   input_data_valid       in   one-cycle strobe per incoming byte
//   particle_data_flag     in   level, selects particle messages (has priority)
//   map_data_flag          in   level, selects map messages
//   data_out               out  byte to write to the destination RAM
//   waddr                  out  destination address taken from the table
//   data_valid             out  destination RAM write strobe
//   start_particle_update  out  pulse with the last particle byte write
// -----------------------------------------------------------------------------
module data_dispatcher_unit #(
  parameter int PARTICLE_MESSAGE_LENGHT_BYTE = 8,
  parameter int MAP_MESSAGE_LENGHT_BYTE      = 10,
  parameter int DATA_WIDTH                   = 8,
  parameter int ADDR_WIDTH                   = 10,
  parameter logic [(PARTICLE_MESSAGE_LENGHT_BYTE+MAP_MESSAGE_LENGHT_BYTE)*ADDR_WIDTH-1:0]
    dispatch_table = {10'h209, 10'h208, 10'h207, 10'h206, 10'h205,
                      10'h204, 10'h203, 10'h202, 10'h201, 10'h200,
                      10'h107, 10'h106, 10'h105, 10'h104,
                      10'h103, 10'h102, 10'h101, 10'h100}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  input_data_valid,
  input  logic                  particle_data_flag,
  input  logic                  map_data_flag,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  data_valid,
  output logic                  start_particle_update
);

  localparam int P_LEN = PARTICLE_MESSAGE_LENGHT_BYTE;
  localparam int M_LEN = MAP_MESSAGE_LENGHT_BYTE;
  localparam int DEPTH = P_LEN + M_LEN;
  localparam int IW    = $clog2(DEPTH);

  localparam logic [IW-1:0] P_LAST = IW'(P_LEN - 1);
  localparam logic [IW-1:0] M_LAST = IW'(M_LEN - 1);
  localparam logic [IW-1:0] M_BASE = IW'(P_LEN);

  typedef enum logic [1:0] {
    MODE_NONE     = 2'd0,
    MODE_PARTICLE = 2'd1,
    MODE_MAP      = 2'd2
  } mode_e;

  // ---------------------------------------------------------------------------
  // Dispatch table ROM
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] table_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
    assign table_mem[gi] = dispatch_table[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Mode selection and byte counter
  // ---------------------------------------------------------------------------
  mode_e         mode_sel;
  mode_e         mode_q;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] cnt_eff;
  logic [IW-1:0] rd_idx;
  logic          accept;
  logic          last_byte;

  always_comb begin
    mode_sel  = MODE_NONE;
    cnt_eff   = cnt_q;
    accept    = 1'b0;
    last_byte = 1'b0;
    rd_idx    = '0;
    cnt_d     = cnt_q;

    if (particle_data_flag)  mode_sel = MODE_PARTICLE;
    else if (map_data_flag)  mode_sel = MODE_MAP;

    // A different mode from the previous cycle starts a message from byte 0,
    // even if the byte that triggers the change arrives in the same cycle.
    if (mode_sel != mode_q) cnt_eff = '0;

    accept    = input_data_valid && (mode_sel != MODE_NONE);
    last_byte = (mode_sel == MODE_PARTICLE) ? (cnt_eff == P_LAST) : (cnt_eff == M_LAST);
    rd_idx    = (mode_sel == MODE_MAP) ? (M_BASE + cnt_eff) : cnt_eff;

    if (mode_sel == MODE_NONE) cnt_d = '0;
    else if (accept)           cnt_d = last_byte ? '0 : cnt_eff + 1'b1;
    else                       cnt_d = cnt_eff;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: latch the byte and the table index
  // ---------------------------------------------------------------------------
  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [IW-1:0]         s1_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_NONE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
    end else begin
      mode_q     <= mode_sel;
      cnt_q      <= cnt_d;
      s1_valid_q <= accept;
      s1_last_q  <= accept && last_byte && (mode_sel == MODE_PARTICLE);
      if (accept) begin
        s1_data_q <= data_in;
        s1_idx_q  <= rd_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered table read (kept free of reset so it maps onto RAM)
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] s2_addr_q;

  always_ff @(posedge clk) begin
    s2_addr_q <= table_mem[s1_idx_q];
  end

  logic                  s2_valid_q;
  logic                  s2_last_q;
  logic [DATA_WIDTH-1:0] s2_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_data_q  <= s1_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: output registers; data/address hold between writes
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  data_valid_q;
  logic                  start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      waddr_q      <= '0;
      data_valid_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      data_valid_q <= s2_valid_q;
      start_q      <= s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        data_out_q <= s2_data_q;
        waddr_q    <= s2_addr_q;
      end
    end
  end

  assign data_out              = data_out_q;
  assign waddr                 = waddr_q;
  assign data_valid            = data_valid_q;
  assign start_particle_update = start_q;

endmodule

// File: tb/tb_data_dispatcher_unit.sv
// -----------------------------------------------------------------------------
// Testbench for data_dispatcher_unit: directed scenarios followed by random
// traffic, checked against a message-level reference model.
// -----------------------------------------------------------------------------
module tb_data_dispatcher_unit;

  localparam int P  = 8;
  localparam int M  = 10;
  localparam int DW = 8;
  localparam int AW = 10;

  function automatic logic [(P+M)*AW-1:0] build_table();
    logic [(P+M)*AW-1:0] t;
    t = '0;
    for (int i = 0; i < P + M; i++) begin
      if (i < P) t[i*AW +: AW] = AW'(32'h100 + i);
      else       t[i*AW +: AW] = AW'(32'h200 + (i - P));
    end
    return t;
  endfunction

  localparam logic [(P+M)*AW-1:0] TBL = build_table();

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          input_data_valid;
  logic          particle_data_flag;
  logic          map_data_flag;
  logic [DW-1:0] data_out;
  logic [AW-1:0] waddr;
  logic          data_valid;
  logic          start_particle_update;

  data_dispatcher_unit #(
    .PARTICLE_MESSAGE_LENGHT_BYTE(P),
    .MAP_MESSAGE_LENGHT_BYTE     (M),
    .DATA_WIDTH                  (DW),
    .ADDR_WIDTH                  (AW),
    .dispatch_table              (TBL)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .data_in              (data_in),
    .input_data_valid     (input_data_valid),
    .particle_data_flag   (particle_data_flag),
    .map_data_flag        (map_data_flag),
    .data_out             (data_out),
    .waddr                (waddr),
    .data_valid           (data_valid),
    .start_particle_update(start_particle_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            m_cnt  = 0;
  int            m_mode = 0;   // 0 none, 1 particle, 2 map
  logic [DW-1:0] held_data = '0;
  logic [AW-1:0] held_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check_eq("overdue_write", 32'(exp_q[0].due), 32'(cyc));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_eq("data_valid", 32'(data_valid), 32'd1);
      check_eq("data_out", 32'(data_out), 32'(e.data));
      check_eq("waddr", 32'(waddr), 32'(e.addr));
      check_eq("start_particle_update", 32'(start_particle_update), 32'(e.last));
      held_data = e.data;
      held_addr = e.addr;
      $display("write addr=0x%03h data=0x%02h start=%0b", e.addr, e.data, e.last);
    end else begin
      check_eq("idle_data_valid", 32'(data_valid), 32'd0);
      check_eq("idle_start", 32'(start_particle_update), 32'd0);
      check_eq("held_data_out", 32'(data_out), 32'(held_data));
      check_eq("held_waddr", 32'(waddr), 32'(held_addr));
    end
  endtask

  // Message-level model: position within the active message selects the
  // destination; a mode change or no mode restarts at position 0.
  task automatic model_update(input logic v, input logic pf, input logic mf, input logic [DW-1:0] b);
    int   cur;
    int   len;
    exp_t e;
    cur = pf ? 1 : (mf ? 2 : 0);
    if (cur != m_mode || cur == 0) m_cnt = 0;
    if (v && cur != 0) begin
      len    = (cur == 1) ? P : M;
      e.due  = cyc + 3;
      e.data = b;
      e.addr = (cur == 1) ? AW'(32'h100 + m_cnt) : AW'(32'h200 + m_cnt);
      e.last = (cur == 1) && (m_cnt == P - 1);
      exp_q.push_back(e);
      m_cnt = (m_cnt + 1) % len;
    end
    m_mode = cur;
  endtask

  task automatic step(input logic v, input logic pf, input logic mf, input logic [DW-1:0] b);
    @(negedge clk);
    check_outputs();
    input_data_valid   = v;
    particle_data_flag = pf;
    map_data_flag      = mf;
    data_in            = b;
    model_update(v, pf, mf, b);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    check_outputs();
    rst_n              = 1'b0;
    input_data_valid   = 1'b0;
    particle_data_flag = 1'b0;
    map_data_flag      = 1'b0;
    data_in            = '0;
    exp_q.delete();
    m_cnt     = 0;
    m_mode    = 0;
    held_data = '0;
    held_addr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
    model_update(1'b0, 1'b0, 1'b0, '0);
  endtask

  logic       r_pf, r_mf, r_v;
  logic [1:0] r_mode;

  initial begin
    rst_n              = 1'b0;
    input_data_valid   = 1'b0;
    particle_data_flag = 1'b0;
    map_data_flag      = 1'b0;
    data_in            = '0;

    apply_reset(3);

    // 1: map message, one strobe every three clocks
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b1, DW'(i));
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, '0);
    end

    // 2: particle message back-to-back
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h11 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

    // 3: ten particle bytes, the last two wrap into a new message
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h20 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);

    // 4: both flags -> particle priority; no flag -> dropped
    step(1'b1, 1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 8'h66);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);

    // 5: map mode for three bytes, then switch to particle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, DW'(8'h30 + i));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

    // 6: reset right after an accept mid-message
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h40 + i));
    apply_reset(1);
    step(1'b1, 1'b1, 1'b0, 8'h88);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Random traffic
    r_pf = 1'b0;
    r_mf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r_mode = 2'($urandom_range(0, 3));
        r_pf   = r_mode[0];
        r_mf   = r_mode[1];
      end
      r_v = ($urandom_range(0, 9) < 7);
      step(r_v, r_pf, r_mf, DW'($urandom));
    end

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);
    check_eq("drain_pending_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
